branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters and a tag check. It sits beside the fetch stage of the RV32I core. Fetch presents the next fetch PC and gets a registered taken/target prediction one cycle later. Execute sends resolved branch outcomes back to train the table.

## Interface
Parameters:
- XLEN, 32, address/target width
- ENTRIES, 256, table depth; power of two, 4..1024
- CNT_W, 2, direction counter width, 1..4
- TAG_W, 8, PC tag bits stored per entry; 0 disables the tag compare

Ports:
- clk  in  1  clock
- res  in  1  reset, synchronous, active-high
- halt  in  1  freeze lookup pipeline
- ready  out  1  table initialised, lookups/updates accepted
- lk_valid  in  1  lookup request
- lk_pc  in  XLEN  fetch PC to predict
- pred_valid  out  1  prediction for previous cycle's lookup
- pred_hit  out  1  valid entry with matching tag
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- upd_valid  in  1  resolved branch update
- upd_pc  in  XLEN  branch PC
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual taken target

## Operation
- IDX_W = clog2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Entry fields: valid, tag[TAG_W], cnt[CNT_W], target[XLEN].
- Taken threshold: TH = 2^(CNT_W-1). Predict taken iff cnt >= TH.
- State machine:
  - INIT: entered on res. An init index starts at 0 and clears one entry's valid bit per cycle. After index ENTRIES-1 is cleared, the block goes to RUN. res asserted during INIT restarts the sweep at 0.
  - RUN: ready=1.
- Lookup, RUN only:
  - pred_hit = valid and tag match.
  - pred_taken = pred_hit and cnt >= TH.
  - pred_target = pred_taken ? target : lk_pc+4, computed modulo 2^XLEN.
- Update, RUN only, applied at the clock edge:
  - Hit: a taken outcome increments cnt, saturating at 2^CNT_W-1. A not-taken outcome decrements cnt, saturating at 0. target is overwritten with upd_target only when upd_taken=1.
  - Miss (invalid or tag mismatch): the entry is allocated with valid=1 and tag written. cnt = TH if taken, else TH-1. target = upd_target if taken, else the old value is kept.
- Updates during INIT are dropped. Lookups during INIT give pred_valid=0 on the next cycle.
- halt:
  - lookup is not captured; all pred_* outputs hold their values;
  - updates and the INIT sweep still proceed.

## Timing
- Reset values, at the first edge with res=1: ready=0, pred_valid=0, pred_hit=0, pred_taken=0, pred_target=0. Table contents other than valid are don't-care.
- After res deasserts, ready rises exactly ENTRIES cycles after the first edge with res low.
- Lookup latency is 1 cycle. lk_* sampled at edge N appear on pred_* after edge N and stay valid for cycle N+1. pred_valid = registered (lk_valid and ready and not halt), except during halt, when it holds.
- Update latency: an update written at edge N is visible to a lookup sampled at edge N+1.
- Same-cycle lookup and update to the same index, at the same edge: see Configuration.
- No backpressure: every request presented in RUN without halt is accepted.

## Configuration
- BP_BYPASS_EN defined: a same-edge update to the lookup's index is forwarded. The prediction uses the post-update valid/tag/cnt/target, exactly as if the update had landed one cycle earlier.
- BP_BYPASS_EN undefined: the lookup reads the pre-update entry contents. The update still commits.

## Test plan
- Init: pulse res for 1 cycle with ENTRIES=256 -> ready=0 for 256 cycles, then 1. A lookup of any PC -> pred_hit=0, pred_target=pc+4.
- Cold train: update pc=0x100, taken, target=0x80, then look up 0x100 -> hit=1, taken=1 (cnt=2), target=0x80.
- Saturation/hysteresis: 3 taken updates at 0x100 give cnt=3. One not-taken update gives cnt=2, still taken. A second not-taken gives cnt=1 -> taken=0, target=0x104.
- Alias, TAG_W=8: train 0x100, then look up 0x100+(ENTRIES*4) -> hit=0. Updating the alias reallocates the entry, and 0x100 then misses.
- Same-edge conflict: lookup and taken update of untrained 0x200 at the same edge -> hit=1 with BP_BYPASS_EN, hit=0 without it. A lookup on the next cycle hits in both builds.
- Reset mid-operation: assert res at init index 100 -> the sweep restarts and ready rises 256 cycles after deassertion. A halt during RUN holds pred_* unchanged while an update still trains the table.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with saturating direction counters and tag check; registered 1-cycle prediction, no backpressure.
// Define BP_BYPASS_EN to forward a same-edge update to a lookup of the same index.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 256,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            res,
  input  logic            halt,
  output logic            ready,
  input  logic            lk_valid,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_valid,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TW    = (TAG_W > 0) ? TAG_W : 1;
  localparam logic [CNT_W-1:0] TH   = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_idx, init_idx_nxt;

  logic [ENTRIES-1:0] valid;
  logic [TW-1:0]      tag_mem [ENTRIES];
  logic [CNT_W-1:0]   cnt_mem [ENTRIES];
  logic [XLEN-1:0]    tgt_mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TW-1:0]    lk_tag, upd_tag;
  logic             upd_en, upd_hit, lk_ok;
  logic [CNT_W-1:0] upd_cnt_new;
  logic [XLEN-1:0]  upd_tgt_new;

  logic             e_valid, lk_hit, lk_taken;
  logic [TW-1:0]    e_tag;
  logic [CNT_W-1:0] e_cnt;
  logic [XLEN-1:0]  e_target, lk_target;

  function automatic logic tag_eq(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (TAG_W == 0) || (a == b);
  endfunction

  assign ready = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    case (state)
      ST_INIT: begin
        init_idx_nxt = init_idx + 1'b1;
        if (init_idx == IDX_W'(ENTRIES - 1)) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Update path: next contents of the entry selected by upd_pc
  always_comb begin
    upd_idx = IDX_W'(upd_pc >> 2);
    upd_tag = TW'(upd_pc >> (IDX_W + 2));
    upd_en  = upd_valid && ready && !res;
    upd_hit = valid[upd_idx] && tag_eq(tag_mem[upd_idx], upd_tag);
    if (upd_hit) begin
      if (upd_taken)
        upd_cnt_new = (cnt_mem[upd_idx] == CMAX) ? CMAX : cnt_mem[upd_idx] + 1'b1;
      else
        upd_cnt_new = (cnt_mem[upd_idx] == '0) ? '0 : cnt_mem[upd_idx] - 1'b1;
    end else begin
      upd_cnt_new = upd_taken ? TH : TH - 1'b1;
    end
    upd_tgt_new = upd_taken ? upd_target : tgt_mem[upd_idx];
  end

  always_ff @(posedge clk) begin
    if (!res && state == ST_INIT) begin
      valid[init_idx] <= 1'b0;
    end else if (upd_en) begin
      valid[upd_idx]   <= 1'b1;
      tag_mem[upd_idx] <= upd_tag;
      cnt_mem[upd_idx] <= upd_cnt_new;
      tgt_mem[upd_idx] <= upd_tgt_new;
    end
  end

  always_comb begin
    lk_idx   = IDX_W'(lk_pc >> 2);
    lk_tag   = TW'(lk_pc >> (IDX_W + 2));
    e_valid  = valid[lk_idx];
    e_tag    = tag_mem[lk_idx];
    e_cnt    = cnt_mem[lk_idx];
    e_target = tgt_mem[lk_idx];
`ifdef BP_BYPASS_EN
    if (upd_en && upd_idx == lk_idx) begin
      e_valid  = 1'b1;
      e_tag    = upd_tag;
      e_cnt    = upd_cnt_new;
      e_target = upd_tgt_new;
    end
`endif
    lk_ok     = lk_valid && ready;
    lk_hit    = lk_ok && e_valid && tag_eq(e_tag, lk_tag);
    lk_taken  = lk_hit && (e_cnt >= TH);
    lk_target = lk_taken ? e_target : lk_pc + XLEN'(4);
  end

  // halt freezes every pred_* output, including pred_valid
  always_ff @(posedge clk) begin
    if (res) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (!halt) begin
      pred_valid  <= lk_ok;
      pred_hit    <= lk_hit;
      pred_taken  <= lk_taken;
      pred_target <= lk_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised bench for branch_predictor against an integer-level table model.
module tb_branch_predictor;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 256;
  localparam int CNT_W   = 2;
  localparam int TAG_W   = 8;
  localparam int IDX_W   = 8;
  localparam int TH      = 2;
  localparam int CMAX    = 3;

  logic clk = 1'b0;
  logic res, halt, lk_valid, upd_valid, upd_taken;
  logic [XLEN-1:0] lk_pc, upd_pc, upd_target;
  logic ready, pred_valid, pred_hit, pred_taken;
  logic [XLEN-1:0] pred_target;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .res(res), .halt(halt), .ready(ready),
    .lk_valid(lk_valid), .lk_pc(lk_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          left;
  bit          e_pv, e_hit, e_tk;
  logic [31:0] e_tg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (IDX_W + 2)) % (1 << TAG_W));
  endfunction

  task automatic predict(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] g);
    int i;
    i = idx_of(pc);
    h = m_valid[i] && (m_tag[i] == tag_of(pc));
    t = h && (m_cnt[i] >= TH);
    g = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == tag_of(pc)) begin
      if (tk) m_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
      else    m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
    end else begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(pc);
      m_cnt[i]   = tk ? TH : TH - 1;
    end
    if (tk) m_tgt[i] = tgt;
  endtask

  // One clock: model the edge from the current inputs, then compare outputs
  task automatic cycle();
    bit run, h, t, was_res;
    logic [31:0] g;
    was_res = res;
    if (res) begin
      e_pv = 0; e_hit = 0; e_tk = 0; e_tg = '0;
      left = ENTRIES;
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    end else begin
      run = (left == 0);
`ifdef BP_BYPASS_EN
      if (run && upd_valid) train(upd_pc, upd_taken, upd_target);
      predict(lk_pc, h, t, g);
`else
      predict(lk_pc, h, t, g);
      if (run && upd_valid) train(upd_pc, upd_taken, upd_target);
`endif
      if (!halt) begin
        e_pv = run && lk_valid;
        if (e_pv) begin e_hit = h; e_tk = t; e_tg = g; end
      end
      if (!run) left--;
    end
    @(posedge clk);
    #1;
    check("ready", 64'(ready), 64'(left == 0));
    check("pred_valid", 64'(pred_valid), 64'(e_pv));
    if (was_res || e_pv) begin
      check("pred_hit", 64'(pred_hit), 64'(e_hit));
      check("pred_taken", 64'(pred_taken), 64'(e_tk));
      check("pred_target", 64'(pred_target), 64'(e_tg));
    end
  endtask

  task automatic idle();
    halt = 0; lk_valid = 0; upd_valid = 0; upd_taken = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle(); lk_valid = 1; lk_pc = pc; cycle();
  endtask

  task automatic update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    idle(); upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tgt; cycle();
  endtask

  // Reset pulse, then count cycles until ready while throwing traffic that must be ignored
  task automatic measure_init();
    int n;
    bit seen;
    n = 0; seen = 0;
    idle(); res = 1; cycle();
    res = 0;
    for (int k = 0; k < ENTRIES + 20 && !seen; k++) begin
      lk_valid = 1'($urandom_range(0, 1)); lk_pc = $urandom;
      upd_valid = 1'($urandom_range(0, 1)); upd_pc = $urandom; upd_taken = 1'($urandom_range(0, 1));
      upd_target = $urandom;
      cycle();
      n++;
      if (ready) seen = 1;
    end
    check("init_len", 64'(n), 64'(ENTRIES));
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = ($urandom_range(0, 2) << (IDX_W + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    return p;
  endfunction

  initial begin
    lk_pc = '0; upd_pc = '0; upd_target = '0;
    idle();
    for (int i = 0; i < ENTRIES; i++) begin m_tag[i] = 0; m_cnt[i] = 0; m_tgt[i] = '0; m_valid[i] = 0; end
    res = 1; cycle();
    check("rst_target", 64'(pred_target), 64'(0));
    measure_init();

    lookup(32'h1234);
    check("cold_hit", 64'(pred_hit), 64'(0));
    check("cold_tgt", 64'(pred_target), 64'(32'h1238));

    update(32'h100, 1, 32'h80);
    lookup(32'h100);
    check("train_taken", 64'(pred_taken), 64'(1));
    check("train_tgt", 64'(pred_target), 64'(32'h80));

    update(32'h100, 1, 32'h80);
    update(32'h100, 1, 32'h80);
    update(32'h100, 0, 32'h0);
    lookup(32'h100);
    check("hyst_taken", 64'(pred_taken), 64'(1));
    update(32'h100, 0, 32'h0);
    lookup(32'h100);
    check("hyst_nt", 64'(pred_taken), 64'(0));
    check("hyst_tgt", 64'(pred_target), 64'(32'h104));

    lookup(32'h100 + ENTRIES * 4);
    check("alias_miss", 64'(pred_hit), 64'(0));
    update(32'h100 + ENTRIES * 4, 1, 32'h40);
    lookup(32'h100);
    check("alias_evict", 64'(pred_hit), 64'(0));

    idle(); lk_valid = 1; lk_pc = 32'h200;
    upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_target = 32'h998;
    cycle();
`ifdef BP_BYPASS_EN
    check("same_edge_hit", 64'(pred_hit), 64'(1));
`else
    check("same_edge_hit", 64'(pred_hit), 64'(0));
`endif
    lookup(32'h200);
    check("next_hit", 64'(pred_hit), 64'(1));

    // halt holds pred_* while training continues
    lookup(32'h200);
    idle(); halt = 1; lk_valid = 1; lk_pc = 32'h300;
    upd_valid = 1; upd_pc = 32'h300; upd_taken = 1; upd_target = 32'h40;
    cycle();
    check("halt_hold_tgt", 64'(pred_target), 64'(32'h998));
    lookup(32'h300);
    check("halt_trained", 64'(pred_target), 64'(32'h40));

    // reset at sweep index 100
    idle(); res = 1; cycle();
    res = 0;
    for (int k = 0; k < 100; k++) cycle();
    measure_init();

    for (int k = 0; k < 3000; k++) begin
      res = (k == 1500);
      halt = ($urandom_range(0, 9) == 0);
      lk_valid = ($urandom_range(0, 9) < 7);
      lk_pc = rand_pc();
      upd_valid = 1'($urandom_range(0, 1));
      upd_pc = ($urandom_range(0, 3) == 0) ? lk_pc : rand_pc();
      upd_taken = ($urandom_range(0, 9) < 6);
      upd_target = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    res = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
